rob_multi: RTL and testbench

Parametrised reorder buffer, the next generation of the single-CDB, full-reset ROB in the Tomasulo core.
- Adds configurable depth and configurable CDB broadcast port count.
- Adds partial flush: squashes only entries younger than a mispredicted branch, instead of clearing everything.
- Adds two combinational operand-query ports for the issue stage.
- Sits between the issue logic (allocate), the CDB scheduler (complete) and the commit unit (retire).

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_ptr.sv | 17 +
 rtl/rob_multi.sv | 139 +++++++++++++
 tb/tb_rob_multi.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared entry layout, default sizes and age helper for the reorder buffer
package rob_pkg;
    localparam int XLEN = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic            taken;
        logic [XLEN-1:0] value;
        logic [4:0]      dest;
        logic            writes;
        logic            is_branch;
        logic            is_store;
        logic            pred_taken;
        logic [XLEN-1:0] pc;
    } rob_entry_t;

    // Distance of an entry index from the head index, modulo the ROB depth.
    function automatic int rob_age(int idx, int head, int depth);
        return (idx - head + depth) % depth;
    endfunction
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrap-bit circular pointer with increment and parallel load
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);
    // Load takes priority over increment.
    always_ff @(posedge clk)
        if (reset) ptr <= '0;
        else if (load) ptr <= load_val;
        else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer with multi-port CDB, partial flush and operand queries
module rob_multi
    import rob_pkg::*;
#(
    parameter int XLEN = rob_pkg::XLEN,
    parameter int DEPTH = rob_pkg::DEPTH,
    parameter int CDB_PORTS = 2,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [4:0]                alloc_dest,
    input  logic                      alloc_writes,
    input  logic                      alloc_is_branch,
    input  logic                      alloc_is_store,
    input  logic                      alloc_pred_taken,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic [CDB_PORTS-1:0]      cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0] cdb_value,
    input  logic [CDB_PORTS-1:0]      cdb_taken,
    input  logic [2*TAG_W-1:0]        qry_tag,
    output logic [1:0]                qry_ready,
    output logic [2*XLEN-1:0]         qry_value,
    output logic                      head_valid,
    output logic [TAG_W-1:0]          head_tag,
    output logic [4:0]                head_dest,
    output logic                      head_writes,
    output logic                      head_is_branch,
    output logic                      head_is_store,
    output logic                      head_pred_taken,
    output logic                      head_taken,
    output logic [XLEN-1:0]           head_value,
    output logic [XLEN-1:0]           head_pc,
    input  logic                      commit,
    input  logic                      flush_valid,
    input  logic [TAG_W-1:0]          flush_tag,
    output logic [TAG_W:0]            count
);
    // Same layout as rob_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic            busy;
        logic            ready;
        logic            taken;
        logic [XLEN-1:0] value;
        logic [4:0]      dest;
        logic            writes;
        logic            is_branch;
        logic            is_store;
        logic            pred_taken;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t ent [DEPTH];
    entry_t h;
    logic [TAG_W:0] head_ptr, tail_ptr, tail_next;
    logic [TAG_W-1:0] head_idx, tail_idx, fage;
    logic [DEPTH-1:0] sq;
    logic empty, flush_hit, do_alloc, do_commit;

    assign head_idx = head_ptr[TAG_W-1:0];
    assign tail_idx = tail_ptr[TAG_W-1:0];
    assign count = tail_ptr - head_ptr;
    assign empty = count == '0;
    assign alloc_ready = count != (TAG_W+1)'(DEPTH);
    assign alloc_tag = tail_idx;
    assign flush_hit = flush_valid & ent[flush_tag].busy;
    assign fage = TAG_W'(rob_age(int'(flush_tag), int'(head_idx), DEPTH));
    assign tail_next = head_ptr + (TAG_W+1)'(fage) + (TAG_W+1)'(1);
    assign do_alloc = alloc_valid & alloc_ready & ~flush_valid;
    assign do_commit = commit & head_valid;

    rob_ptr #(.W(TAG_W+1)) u_head (
        .clk(clk), .reset(reset), .inc(do_commit), .load(1'b0), .load_val('0), .ptr(head_ptr)
    );
    rob_ptr #(.W(TAG_W+1)) u_tail (
        .clk(clk), .reset(reset), .inc(do_alloc), .load(flush_hit), .load_val(tail_next), .ptr(tail_ptr)
    );

    assign h = empty ? '0 : ent[head_idx];
    assign head_valid = h.busy & h.ready;
    assign head_tag = empty ? '0 : head_idx;
    assign head_dest = h.dest;
    assign head_writes = h.writes;
    assign head_is_branch = h.is_branch;
    assign head_is_store = h.is_store;
    assign head_pred_taken = h.pred_taken;
    assign head_taken = h.taken;
    assign head_value = h.value;
    assign head_pc = h.pc;

    // Mark entries strictly younger than the flushing branch for squash.
    always_comb begin
        sq = '0;
        for (int i = 0; i < DEPTH; i++)
            sq[i] = flush_hit && rob_age(i, int'(head_idx), DEPTH) > int'(fage);
    end

    // Entry updates: CDB writes (lowest port last so it wins), commit, squash, then allocate.
    always_ff @(posedge clk)
        if (reset) ent <= '{default: '0};
        else begin
            for (int p = CDB_PORTS - 1; p >= 0; p--)
                if (cdb_valid[p] && ent[cdb_tag[p*TAG_W +: TAG_W]].busy && !sq[cdb_tag[p*TAG_W +: TAG_W]]) begin
                    ent[cdb_tag[p*TAG_W +: TAG_W]].ready <= 1'b1;
                    ent[cdb_tag[p*TAG_W +: TAG_W]].value <= cdb_value[p*XLEN +: XLEN];
                    ent[cdb_tag[p*TAG_W +: TAG_W]].taken <= cdb_taken[p];
                end
            if (do_commit) ent[head_idx].busy <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                if (sq[i]) ent[i].busy <= 1'b0;
            if (do_alloc)
                ent[tail_idx] <= '{busy: 1'b1, ready: 1'b0, taken: 1'b0, value: '0,
                                   dest: alloc_dest, writes: alloc_writes, is_branch: alloc_is_branch,
                                   is_store: alloc_is_store, pred_taken: alloc_pred_taken, pc: alloc_pc};
        end

    for (genvar q = 0; q < 2; q++) begin : g_qry
        logic [TAG_W-1:0] t;
        logic hit;
        logic [XLEN-1:0] v;
        assign t = qry_tag[q*TAG_W +: TAG_W];
        // Bypass a same-cycle CDB broadcast; the lowest matching port wins.
        always_comb begin
            hit = 1'b0;
            v = ent[t].value;
            for (int p = CDB_PORTS - 1; p >= 0; p--)
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) begin
                    hit = 1'b1;
                    v = cdb_value[p*XLEN +: XLEN];
                end
        end
        assign qry_ready[q] = ent[t].busy & (ent[t].ready | hit);
        assign qry_value[q*XLEN +: XLEN] = ent[t].busy ? v : '0;
    end
endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed scenarios plus randomized run against a queue-based ROB model
module tb_rob_multi;
    localparam int D = 4;
    localparam int TW = 2;
    localparam int XL = 32;

    logic clk = 0;
    logic reset = 1;
    logic alloc_valid = 0, alloc_writes = 0, alloc_is_branch = 0, alloc_is_store = 0, alloc_pred_taken = 0;
    logic [4:0] alloc_dest = 0;
    logic [XL-1:0] alloc_pc = 0;
    logic [1:0] cdb_valid = 0, cdb_taken = 0;
    logic [2*TW-1:0] cdb_tag = 0, qry_tag = 0;
    logic [2*XL-1:0] cdb_value = 0;
    logic commit = 0, flush_valid = 0;
    logic [TW-1:0] flush_tag = 0;
    logic alloc_ready, head_valid, head_writes, head_is_branch, head_is_store, head_pred_taken, head_taken;
    logic [TW-1:0] alloc_tag, head_tag;
    logic [1:0] qry_ready;
    logic [2*XL-1:0] qry_value;
    logic [4:0] head_dest;
    logic [XL-1:0] head_value, head_pc;
    logic [TW:0] count;

    int n_checks = 0;
    int n_fail = 0;

    rob_multi #(.XLEN(XL), .DEPTH(D), .CDB_PORTS(2)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_dest(alloc_dest), .alloc_writes(alloc_writes), .alloc_is_branch(alloc_is_branch),
        .alloc_is_store(alloc_is_store), .alloc_pred_taken(alloc_pred_taken), .alloc_pc(alloc_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_value(qry_value),
        .head_valid(head_valid), .head_tag(head_tag), .head_dest(head_dest), .head_writes(head_writes),
        .head_is_branch(head_is_branch), .head_is_store(head_is_store), .head_pred_taken(head_pred_taken),
        .head_taken(head_taken), .head_value(head_value), .head_pc(head_pc),
        .commit(commit), .flush_valid(flush_valid), .flush_tag(flush_tag), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: program-order queue of live tags plus per-tag fields.
    int m_q[$];
    int m_next = 0;
    logic m_ready[D], m_taken[D], m_wr[D], m_br[D], m_st[D], m_pt[D];
    logic [4:0] m_dest[D];
    logic [XL-1:0] m_val[D], m_pc[D];

    function automatic int qpos(int t);
        foreach (m_q[k]) if (m_q[k] == t) return k;
        return -1;
    endfunction

    task automatic model_step();
        int n0, pos, t, kp;
        bit fl, hv;
        bit seen[D];
        if (reset) begin
            m_q.delete();
            m_next = 0;
            return;
        end
        seen = '{default: 0};
        n0 = m_q.size();
        pos = qpos(int'(flush_tag));
        fl = flush_valid && pos >= 0;
        hv = n0 > 0 && m_ready[m_q[0]];
        for (int p = 0; p < 2; p++) begin
            t = int'(cdb_tag[p*TW +: TW]);
            if (cdb_valid[p] && !seen[t]) begin
                seen[t] = 1;
                kp = qpos(t);
                if (kp >= 0 && !(fl && kp > pos)) begin
                    m_ready[t] = 1;
                    m_val[t] = cdb_value[p*XL +: XL];
                    m_taken[t] = cdb_taken[p];
                end
            end
        end
        if (fl) begin
            while (m_q.size() > pos + 1) void'(m_q.pop_back());
            m_next = (int'(flush_tag) + 1) % D;
        end
        if (commit && hv) void'(m_q.pop_front());
        if (alloc_valid && n0 < D && !flush_valid) begin
            t = m_next;
            m_ready[t] = 0; m_taken[t] = 0; m_val[t] = 0;
            m_dest[t] = alloc_dest; m_wr[t] = alloc_writes; m_br[t] = alloc_is_branch;
            m_st[t] = alloc_is_store; m_pt[t] = alloc_pred_taken; m_pc[t] = alloc_pc;
            m_q.push_back(t);
            m_next = (m_next + 1) % D;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        alloc_valid = 0; alloc_writes = 0; alloc_is_branch = 0; alloc_is_store = 0; alloc_pred_taken = 0;
        alloc_dest = 0; alloc_pc = 0; cdb_valid = 0; cdb_taken = 0; cdb_tag = 0; cdb_value = 0;
        qry_tag = 0; commit = 0; flush_valid = 0; flush_tag = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
        clr();
    endtask

    task automatic alloc_n(int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1; alloc_dest = 5'(i); alloc_pc = 32'h1000 + 32'(i);
            tick();
        end
        alloc_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; alloc_valid = 1; cdb_valid = 2'b11; cdb_tag = 4'b0100;
        tick(); tick();
        reset = 0; clr();
        #1;
        n_checks++;
        if ({alloc_ready, count, alloc_tag, head_valid} !== {1'b1, 3'd0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_ctl: got rdy=%b cnt=%0d tag=%0d hv=%b want 1/0/0/0", alloc_ready, count, alloc_tag, head_valid);
        end
        n_checks++;
        if ({head_value, head_pc, head_dest, qry_ready, qry_value} !== '0) begin
            n_fail++; $display("FAIL reset_data: got val=%h pc=%h dest=%0d qr=%b qv=%h want all 0", head_value, head_pc, head_dest, qry_ready, qry_value);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            alloc_valid = 1; alloc_dest = 5'(i + 1); alloc_pc = 32'(100 + i); alloc_writes = 1;
            #1;
            n_checks++;
            if (alloc_tag !== TW'(i) || alloc_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_tag%0d: got tag=%0d rdy=%b want %0d/1", i, alloc_tag, alloc_ready, i);
            end
            tick();
        end
        #1;
        n_checks++;
        if (alloc_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++; $display("FAIL fill_full: got rdy=%b cnt=%0d want 0/4", alloc_ready, count);
        end
        alloc_pc = 999;
        tick();
        clr();
        #1;
        n_checks++;
        if (count !== 3'd4 || alloc_tag !== 2'd0 || head_pc !== 32'd100 || head_dest !== 5'd1) begin
            n_fail++; $display("FAIL fill_refuse: got cnt=%0d tag=%0d pc=%0d dest=%0d want 4/0/100/1", count, alloc_tag, head_pc, head_dest);
        end
    endtask

    task automatic test_cdb();
        cdb_valid = 2'b11; cdb_tag = {2'd0, 2'd1}; cdb_value = {32'h5A, 32'hA5};
        #1;
        n_checks++;
        if (head_valid !== 1'b0) begin
            n_fail++; $display("FAIL cdb_early: got hv=%b want 0", head_valid);
        end
        tick();
        clr();
        #1;
        n_checks++;
        if (head_valid !== 1'b1 || head_value !== 32'h5A || head_tag !== 2'd0) begin
            n_fail++; $display("FAIL cdb_head0: got hv=%b val=%h tag=%0d want 1/5a/0", head_valid, head_value, head_tag);
        end
        commit = 1;
        tick();
        commit = 0;
        #1;
        n_checks++;
        if (head_tag !== 2'd1 || head_value !== 32'hA5 || count !== 3'd3) begin
            n_fail++; $display("FAIL cdb_head1: got tag=%0d val=%h cnt=%0d want 1/a5/3", head_tag, head_value, count);
        end
    endtask

    task automatic test_collision();
        cdb_valid = 2'b11; cdb_tag = {2'd2, 2'd2}; cdb_value = {32'h22, 32'h11};
        tick();
        clr();
        qry_tag = {2'd0, 2'd2};
        #1;
        n_checks++;
        if (qry_ready !== 2'b01 || qry_value !== {32'h0, 32'h11}) begin
            n_fail++; $display("FAIL collision: got qr=%b qv=%h want 01/0000000000000011", qry_ready, qry_value);
        end
        clr();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(4);
        flush_valid = 1; flush_tag = 1;
        cdb_valid = 2'b11; cdb_tag = {2'd0, 2'd3}; cdb_value = {32'h50, 32'h33};
        tick();
        clr();
        #1;
        n_checks++;
        if (count !== 3'd2 || alloc_tag !== 2'd2 || head_valid !== 1'b1 || head_value !== 32'h50) begin
            n_fail++; $display("FAIL flush_part: got cnt=%0d tag=%0d hv=%b val=%h want 2/2/1/50", count, alloc_tag, head_valid, head_value);
        end
        cdb_valid = 2'b01; cdb_tag = {2'd0, 2'd3}; cdb_value = {32'h0, 32'h33};
        tick();
        clr();
        qry_tag = {2'd3, 2'd3};
        #1;
        n_checks++;
        if (qry_ready !== 2'b00 || qry_value !== '0) begin
            n_fail++; $display("FAIL flush_stale: got qr=%b qv=%h want 0/0", qry_ready, qry_value);
        end
        clr();
        alloc_valid = 1;
        #1;
        n_checks++;
        if (alloc_tag !== 2'd2) begin
            n_fail++; $display("FAIL flush_realloc: got tag=%0d want 2", alloc_tag);
        end
        tick();
        clr();
        flush_valid = 1; flush_tag = 3; alloc_valid = 1;
        tick();
        clr();
        #1;
        n_checks++;
        if (count !== 3'd3 || alloc_tag !== 2'd3) begin
            n_fail++; $display("FAIL flush_ignored: got cnt=%0d tag=%0d want 3/3", count, alloc_tag);
        end
        flush_valid = 1; flush_tag = 0; alloc_valid = 1;
        tick();
        clr();
        #1;
        n_checks++;
        if (count !== 3'd1 || alloc_tag !== 2'd1) begin
            n_fail++; $display("FAIL flush_prio: got cnt=%0d tag=%0d want 1/1", count, alloc_tag);
        end
    endtask

    task automatic test_wrap();
        int ord[4];
        logic [31:0] vals[4];
        ord = '{3, 0, 1, 2};
        vals = '{32'h103, 32'h200, 32'h201, 32'h202};
        do_reset();
        alloc_n(4);
        cdb_valid = 2'b11; cdb_tag = {2'd1, 2'd0}; cdb_value = {32'h101, 32'h100};
        tick();
        cdb_tag = {2'd3, 2'd2}; cdb_value = {32'h103, 32'h102};
        tick();
        clr();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (head_tag !== TW'(k) || head_valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_pop%0d: got tag=%0d hv=%b want %0d/1", k, head_tag, head_valid, k);
            end
            commit = 1;
            tick();
            commit = 0;
        end
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1;
            #1;
            n_checks++;
            if (alloc_tag !== TW'(k)) begin
                n_fail++; $display("FAIL wrap_alloc%0d: got tag=%0d want %0d", k, alloc_tag, k);
            end
            tick();
            alloc_valid = 0;
        end
        #1;
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++; $display("FAIL wrap_count: got %0d want 4", count);
        end
        cdb_valid = 2'b11; cdb_tag = {2'd1, 2'd0}; cdb_value = {32'h201, 32'h200};
        tick();
        cdb_valid = 2'b01; cdb_tag = {2'd0, 2'd2}; cdb_value = {32'h0, 32'h202};
        tick();
        clr();
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (head_tag !== TW'(ord[k]) || head_value !== vals[k] || head_valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_order%0d: got tag=%0d val=%h want %0d/%h", k, head_tag, head_value, ord[k], vals[k]);
            end
            commit = 1;
            tick();
            commit = 0;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        alloc_n(3);
        qry_tag = {2'd2, 2'd2};
        #1;
        n_checks++;
        if (qry_ready !== 2'b00) begin
            n_fail++; $display("FAIL bypass_pre: got qr=%b want 00", qry_ready);
        end
        cdb_valid = 2'b10; cdb_tag = {2'd2, 2'd0}; cdb_value = {32'h77, 32'h0};
        #1;
        n_checks++;
        if (qry_ready !== 2'b11 || qry_value !== {32'h77, 32'h77}) begin
            n_fail++; $display("FAIL bypass_hit: got qr=%b qv=%h want 11/0000007700000077", qry_ready, qry_value);
        end
        tick();
        clr();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(3);
        reset = 1; cdb_valid = 2'b11; cdb_tag = {2'd1, 2'd0}; commit = 1;
        tick();
        reset = 0;
        clr();
        #1;
        n_checks++;
        if (count !== 3'd0 || head_valid !== 1'b0 || alloc_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: got cnt=%0d hv=%b rdy=%b want 0/0/1", count, head_valid, alloc_ready);
        end
    endtask

    task automatic test_random();
        logic [76:0] eh;
        logic [5:0] ea;
        logic [1:0] er;
        logic [63:0] ev;
        int h, t;
        bit hit, busy;
        logic [31:0] cv;
        do_reset();
        repeat (3000) begin
            alloc_valid = 1'($urandom); alloc_dest = 5'($urandom); alloc_writes = 1'($urandom);
            alloc_is_branch = 1'($urandom); alloc_is_store = 1'($urandom); alloc_pred_taken = 1'($urandom);
            alloc_pc = $urandom; cdb_valid = 2'($urandom); cdb_tag = 4'($urandom);
            cdb_value = {$urandom, $urandom}; cdb_taken = 2'($urandom); qry_tag = 4'($urandom);
            commit = 1'($urandom); flush_valid = $urandom_range(0, 7) == 0; flush_tag = 2'($urandom);
            reset = $urandom_range(0, 199) == 0;
            #1;
            ea = {m_q.size() < D, TW'(m_next), 3'(m_q.size())};
            n_checks++;
            if ({alloc_ready, alloc_tag, count} !== ea) begin
                n_fail++; $display("FAIL rand_alloc: got rdy/tag/cnt=%b want %b", {alloc_ready, alloc_tag, count}, ea);
            end
            eh = '0;
            if (m_q.size() > 0) begin
                h = m_q[0];
                eh = {m_ready[h], TW'(h), m_dest[h], m_wr[h], m_br[h], m_st[h], m_pt[h], m_taken[h], m_val[h], m_pc[h]};
            end
            n_checks++;
            if ({head_valid, head_tag, head_dest, head_writes, head_is_branch, head_is_store, head_pred_taken,
                 head_taken, head_value, head_pc} !== eh) begin
                n_fail++; $display("FAIL rand_head: got hv=%b tag=%0d val=%h pc=%h want %h", head_valid, head_tag, head_value, head_pc, eh);
            end
            for (int i = 0; i < 2; i++) begin
                t = int'(qry_tag[i*TW +: TW]);
                hit = 0; cv = 0;
                for (int p = 1; p >= 0; p--)
                    if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == t) begin
                        hit = 1; cv = cdb_value[p*XL +: XL];
                    end
                busy = qpos(t) >= 0;
                er[i] = busy && (m_ready[t] || hit);
                ev[i*XL +: XL] = !busy ? 32'h0 : hit ? cv : m_val[t];
            end
            n_checks++;
            if (qry_ready !== er || qry_value !== ev) begin
                n_fail++; $display("FAIL rand_qry: got qr=%b qv=%h want %b/%h", qry_ready, qry_value, er, ev);
            end
            tick();
        end
        reset = 0;
        clr();
    endtask

    initial begin
        clr();
        test_reset();
        test_fill();
        test_cdb();
        test_collision();
        test_flush();
        test_wrap();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
